// File: rtl/prga.sv
// ARC4 keystream generator: decrypts a length-prefixed ciphertext RAM into the plaintext RAM using the scheduled S RAM.
// Optional macro PRGA_PRINTABLE_CHK_EN adds a printable-ASCII check with early abort and a pt_ok status flag.
module prga #(
   parameter int MEM_AW = 8,
   parameter int DW     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   output logic [MEM_AW-1:0] s_addr,
   input  logic [DW-1:0]     s_rddata,
   output logic [DW-1:0]     s_wrdata,
   output logic              s_wren,
   output logic [MEM_AW-1:0] ct_addr,
   input  logic [DW-1:0]     ct_rddata,
   output logic [MEM_AW-1:0] pt_addr,
   output logic [DW-1:0]     pt_wrdata,
   output logic              pt_wren,
   output logic              pt_ok
);

   typedef enum logic [3:0] {
      IDLE, RD_LEN, WAIT_LEN, WR_LEN,
      RD_SI, WAIT_SI, RD_SJ, WAIT_SJ,
      WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_PT
   } state_t;

   state_t            state_reg;
   logic [MEM_AW-1:0] i_reg, j_reg, k_reg, len_reg;
   logic [DW-1:0]     si_reg, sj_reg;
   logic [DW-1:0]     pad_byte;

   assign pad_byte = s_rddata ^ ct_rddata;

`ifdef PRGA_PRINTABLE_CHK_EN
   logic pt_ok_reg;
   assign pt_ok = pt_ok_reg;
`else
   assign pt_ok = 1'b1;
`endif

   // Outputs are registered: each transition sets up the bus values the next state presents.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         rdy       <= 1'b1;
         s_addr    <= '0;
         s_wrdata  <= '0;
         s_wren    <= 1'b0;
         ct_addr   <= '0;
         pt_addr   <= '0;
         pt_wrdata <= '0;
         pt_wren   <= 1'b0;
         i_reg     <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
         len_reg   <= '0;
         si_reg    <= '0;
         sj_reg    <= '0;
`ifdef PRGA_PRINTABLE_CHK_EN
         pt_ok_reg <= 1'b1;
`endif
      end else begin
         s_wren  <= 1'b0;
         pt_wren <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (en) begin
                  rdy       <= 1'b0;
                  i_reg     <= '0;
                  j_reg     <= '0;
                  k_reg     <= '0;
                  ct_addr   <= '0;
`ifdef PRGA_PRINTABLE_CHK_EN
                  pt_ok_reg <= 1'b1;
`endif
                  state_reg <= RD_LEN;
               end
            end
            RD_LEN:   state_reg <= WAIT_LEN;
            WAIT_LEN: begin
               len_reg   <= MEM_AW'(ct_rddata);
               pt_addr   <= '0;
               pt_wrdata <= ct_rddata;
               pt_wren   <= 1'b1;
               state_reg <= WR_LEN;
            end
            WR_LEN: begin
               if (len_reg == '0) begin
                  rdy       <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  i_reg     <= i_reg + 1'b1;
                  s_addr    <= i_reg + 1'b1;
                  state_reg <= RD_SI;
               end
            end
            RD_SI:    state_reg <= WAIT_SI;
            WAIT_SI: begin
               si_reg    <= s_rddata;
               j_reg     <= MEM_AW'(j_reg + s_rddata);
               s_addr    <= MEM_AW'(j_reg + s_rddata);
               state_reg <= RD_SJ;
            end
            RD_SJ:    state_reg <= WAIT_SJ;
            WAIT_SJ: begin
               sj_reg    <= s_rddata;
               s_addr    <= i_reg;
               s_wrdata  <= s_rddata;
               s_wren    <= 1'b1;
               state_reg <= WR_SI;
            end
            WR_SI: begin
               s_addr    <= j_reg;
               s_wrdata  <= si_reg;
               s_wren    <= 1'b1;
               state_reg <= WR_SJ;
            end
            // Pre-swap si+sj equals post-swap s[i]+s[j], so no re-read is needed.
            WR_SJ: begin
               s_addr    <= MEM_AW'(si_reg + sj_reg);
               ct_addr   <= k_reg + 1'b1;
               state_reg <= RD_PAD;
            end
            RD_PAD:   state_reg <= WAIT_PAD;
            WAIT_PAD: begin
               pt_addr   <= k_reg + 1'b1;
               pt_wrdata <= pad_byte;
               pt_wren   <= 1'b1;
               k_reg     <= k_reg + 1'b1;
`ifdef PRGA_PRINTABLE_CHK_EN
               if (pad_byte < 8'h20 || pad_byte > 8'h7E)
                  pt_ok_reg <= 1'b0;
`endif
               state_reg <= WR_PT;
            end
            WR_PT: begin
               if (k_reg == len_reg || !pt_ok) begin
                  rdy       <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  i_reg     <= i_reg + 1'b1;
                  s_addr    <= i_reg + 1'b1;
                  state_reg <= RD_SI;
               end
            end
            default: begin
               rdy       <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: table-driven short runs on identity S plus a long KSA-scheduled run, reset abort and handshake sequences.
module tb_prga;

   logic       clk = 1'b0;
   logic       rst, en, rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
   logic       s_wren, pt_wren, pt_ok;

   always #5 clk = ~clk;

   prga #(.MEM_AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .ct_addr(ct_addr), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .pt_ok(pt_ok)
   );

   logic [7:0] s_mem [256];
   logic [7:0] s_init [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] m_s [256];
   logic [7:0] exp_pt [256];
   logic       load_mems = 1'b0;

   int s_wr_cnt = 0, len_wr_cnt = 0, both_cnt = 0;
   int errors = 0, checks = 0;

   // Memories with 1-cycle registered read; load_mems copies S from s_init and blanks PT.
   always @(posedge clk) begin
      if (load_mems) begin
         for (int n = 0; n < 256; n++) begin
            s_mem[n]  <= s_init[n];
            pt_mem[n] <= 8'hEE;
         end
      end else begin
         if (s_wren) s_mem[s_addr] <= s_wrdata;
         if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
      end
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
         if (pt_wren && pt_addr == 8'h00) len_wr_cnt <= len_wr_cnt + 1;
         if (s_wren && pt_wren) both_cnt <= both_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   task automatic load();
      @(negedge clk);
      load_mems = 1'b1;
      @(negedge clk);
      load_mems = 1'b0;
   endtask

   task automatic set_identity();
      for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
   endtask

   // Reference RC4 PRGA: picks random printable plaintext and derives ciphertext from the keystream.
   task automatic model_gen(input int len);
      logic [7:0] i, j, t, p;
      for (int n = 0; n < 256; n++) m_s[n] = s_init[n];
      i = 0; j = 0;
      ct_mem[0] = 8'(len); exp_pt[0] = 8'(len);
      for (int k = 1; k <= len; k++) begin
         i = i + 8'd1;
         j = j + m_s[i];
         t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
         t = m_s[i] + m_s[j];
         p = 8'($urandom_range(32, 126));
         exp_pt[k] = p;
         ct_mem[k] = p ^ m_s[t];
      end
   endtask

   task automatic run(output int cyc);
      bit to;
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      chk("rdy_drop", {31'd0, rdy}, 32'd0);
      cyc = 0; to = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk); #1;
         cyc++;
         if (rdy) begin to = 1'b0; break; end
      end
      if (to) begin
         errors++;
         $display("FAIL run_timeout: rdy still %0b after %0d cycles", rdy, cyc);
      end
   endtask

   typedef struct {
      logic [7:0]  len;
      logic [31:0] ct;
      logic [31:0] pt;
      int          cyc;
      logic        ok;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int cyc, sw0, lw0, bad;
      logic [7:0] key [3];
      logic [7:0] j, t;

      vecs[0] = '{8'd2, 32'h00_40_41_02, 32'hEE_45_43_02, 21, 1'b1};
      vecs[1] = '{8'd0, 32'h00_00_00_00, 32'hEE_EE_EE_00, 3,  1'b1};
      vecs[2] = '{8'd1, 32'h00_00_41_01, 32'hEE_EE_43_01, 12, 1'b1};
      vecs[3] = '{8'd3, 32'h63_62_61_03, 32'h64_67_63_03, 30, 1'b1};
`ifdef PRGA_PRINTABLE_CHK_EN
      vecs[4] = '{8'd3, 32'h40_FF_41_03, 32'hEE_FA_43_03, 21, 1'b0};
`else
      vecs[4] = '{8'd3, 32'h40_FF_41_03, 32'h47_FA_43_03, 30, 1'b1};
`endif

      for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;
      set_identity();
      rst = 1'b1; en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", {31'd0, rdy}, 32'd1);
      chk("rst_pt_ok", {31'd0, pt_ok}, 32'd1);
      chk("rst_wren", {30'd0, s_wren, pt_wren}, 32'd0);
      chk("rst_addr", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
      chk("rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven short runs on identity S
      for (int v = 0; v < 5; v++) begin
         set_identity();
         ct_mem[0] = vecs[v].ct[7:0];   ct_mem[1] = vecs[v].ct[15:8];
         ct_mem[2] = vecs[v].ct[23:16]; ct_mem[3] = vecs[v].ct[31:24];
         load();
         sw0 = s_wr_cnt;
         run(cyc);
         chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
         chk($sformatf("v%0d_pt", v), {pt_mem[3], pt_mem[2], pt_mem[1], pt_mem[0]}, vecs[v].pt);
         chk($sformatf("v%0d_pt_ok", v), {31'd0, pt_ok}, {31'd0, vecs[v].ok});
         chk($sformatf("v%0d_s_writes", v), s_wr_cnt - sw0, 2 * ((vecs[v].cyc - 3) / 9));
         if (v == 0) begin
            bad = 0;
            for (int n = 0; n < 256; n++)
               if (n != 2 && n != 3 && s_mem[n] !== 8'(n)) bad++;
            chk("v0_s2", s_mem[2], 8'h03);
            chk("v0_s3", s_mem[3], 8'h02);
            chk("v0_s_others", bad, 0);
         end
      end

      // Long run: S scheduled by init+ksa with key 00033C
      key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
      set_identity();
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = j + s_init[n] + key[n % 3];
         t = s_init[n]; s_init[n] = s_init[j]; s_init[j] = t;
      end
      model_gen(255);
      load();
      run(cyc);
      chk("ksa_cycles", cyc, 3 + 255 * 9);
      bad = 0;
      for (int n = 0; n < 256; n++) if (pt_mem[n] !== exp_pt[n]) bad++;
      chk("ksa_pt_mismatches", bad, 0);
      bad = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad++;
      chk("ksa_final_s_mismatches", bad, 0);

      // Reset during byte 5 of a 20-byte run, then rerun from fresh S
      set_identity();
      model_gen(20);
      load();
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (43) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_rdy", {31'd0, rdy}, 32'd1);
      chk("abort_wren", {30'd0, s_wren, pt_wren}, 32'd0);
      sw0 = s_wr_cnt; lw0 = len_wr_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_quiet", (s_wr_cnt - sw0) + (len_wr_cnt - lw0), 0);
      load();
      run(cyc);
      chk("rerun_cycles", cyc, 3 + 20 * 9);
      bad = 0;
      for (int n = 0; n <= 20; n++) if (pt_mem[n] !== exp_pt[n]) bad++;
      chk("rerun_pt_mismatches", bad, 0);

      // en held high for two runs, then a pulse while busy is ignored
      set_identity();
      ct_mem[0] = 8'h02; ct_mem[1] = 8'h41; ct_mem[2] = 8'h40;
      load();
      lw0 = len_wr_cnt;
      @(negedge clk);
      en = 1'b1;
      repeat (25) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      chk("busy_rdy_low", {31'd0, rdy}, 32'd0);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      bad = 1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (rdy) begin bad = 0; break; end
      end
      chk("held_en_done", bad, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("held_en_runs", len_wr_cnt - lw0, 2);
      chk("held_en_rdy", {31'd0, rdy}, 32'd1);

      chk("wren_overlap", both_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- Third stage of the ARC4 decryption pipeline: init → ksa → prga.
- After ksa has scheduled the 256-byte S RAM, prga generates the keystream, XORs it with the length-prefixed ciphertext RAM, and writes the length-prefixed plaintext RAM.
- S is left in its post-PRGA state.
- Controlled by the top-level FSM through the same en/rdy handshake used by init and ksa.

Parameters:
- MEM_AW, 8, address width of the S, CT and PT memories (256 entries).
- DW, 8, data width of every memory word.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only while rdy=1.
- rdy  output  1  1 = idle and ready to accept en.
- s_addr  output  8  S RAM address.
- s_rddata  input  8  S RAM read data, valid 1 cycle after s_addr is presented.
- s_wrdata  output  8  S RAM write data.
- s_wren  output  1  S RAM write enable.
- ct_addr  output  8  ciphertext RAM address (read-only; 1-cycle latency).
- ct_rddata  input  8  ciphertext read data.
- pt_addr  output  8  plaintext RAM address.
- pt_wrdata  output  8  plaintext write data.
- pt_wren  output  1  plaintext write enable.
- pt_ok  output  1  plaintext status (see Optional Feature).

Behaviour:
- Reset values: rdy=1, pt_ok=1, all wren=0, all addresses=0, all wrdata=0, internal i=j=k=len=0, state=IDLE. Reset mid-operation aborts immediately; no further writes occur after the reset cycle.
- Handshake: in IDLE with rdy=1, en=1 is accepted on that edge, and rdy drops on the next cycle. en while rdy=0 is ignored. rdy returns to 1 in the cycle after the last memory write. Back-to-back en is allowed.
- States and transitions:
  - IDLE
  - RD_LEN: ct_addr=0
  - WR_LEN: pt[0]=len; if len=0 → IDLE
  - RD_SI: i=i+1 mod 256, s_addr=i
  - WAIT_SI
  - RD_SJ: latch si; j=j+si mod 256, s_addr=j
  - WAIT_SJ
  - WR_SI: latch sj; s[i]=sj
  - WR_SJ: s[j]=si
  - RD_PAD: s_addr=(si+sj) mod 256, ct_addr=k
  - WAIT_PAD
  - WR_PT: pt[k]=s_rddata ^ ct_rddata; k=k+1; if k=len → IDLE, else → RD_SI
- Algorithm start conditions: i, j and k are cleared on acceptance. k runs 1..len inclusive; len is ct[0], taken as unsigned 0..255.
- Arithmetic: all index sums are 8-bit and wrap mod 256; carries are discarded.
- At most one of s_wren/pt_wren is high per cycle, and s_wren is never high in the same cycle as an S read address needed later.
- i=j case: the swap writes the same value twice; the result is correct and no special-casing is needed.
- Pad index uses the pre-swap si/sj values, which equal post-swap s[j]/s[i]. The sum is commutative, so the result is correct.
- Throughput: exactly 9 cycles per byte, plus 3 cycles overhead (RD_LEN, wait, WR_LEN).

Optional Feature:
- Macro PRGA_PRINTABLE_CHK_EN.
- Defined:
  - Each byte written to pt[k] (k≥1) is checked against 0x20..0x7E.
  - On the first out-of-range byte: that byte is still written, pt_ok is cleared, and the FSM returns to IDLE immediately (early abort for the key cracker).
  - pt_ok is set to 1 on each accepted en and holds its value while idle.
- Undefined: pt_ok is constant 1, no check is made, and all len bytes are always processed.

Test Plan:
- S identity (s[k]=k), ct={02,41,40}, pulse en → pt={02,43,45}; S afterwards: s[2]=03, s[3]=02, all others unchanged; rdy high after 21 cycles.
- ct[0]=00 → pt[0]=00 only, no S writes, rdy back after 3 cycles, pt_ok=1.
- S produced by init+ksa with key 00033C (s[0]=B4), 255-byte known ciphertext → plaintext matches the golden file byte-for-byte; check wrap of i through 0xFF→0x00.
- Assert rst during byte 5 of a 20-byte run → next cycle rdy=1, no wren; re-run from fresh S gives correct pt.
- en held high continuously, plus en pulse while busy → exactly one run per accepted en; busy-time pulse is ignored.
- PRGA_PRINTABLE_CHK_EN defined, identity S, ct={03,41,FF,40} → pt[1]=43, pt[2]=FF^05=FA written, pt_ok=0, pt[3] not written, rdy=1.
